// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus bundle: ALU/MEM completion handshakes, register-unit write port,
// issue-stage hazard query and the pending-write vector.
interface regfile_wb_arbiter_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
);
  localparam int unsigned RW = $clog2(NREG);

  logic            alu_valid;
  logic [RW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            mem_valid;
  logic [RW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;

  logic            ru_wr;
  logic [RW-1:0]   ru_rd;
  logic [XLEN-1:0] ru_data;

  logic            iss_valid;
  logic [RW-1:0]   iss_rs1;
  logic [RW-1:0]   iss_rs2;
  logic [RW-1:0]   iss_rd;
  logic            iss_stall;

  logic [NREG-1:0] busy;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  mem_valid, mem_rd, mem_data,
    output mem_ready,
    output ru_wr, ru_rd, ru_data,
    input  iss_valid, iss_rs1, iss_rs2, iss_rd,
    output iss_stall,
    output busy
  );

  // Pipeline / register-unit side
  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output mem_valid, mem_rd, mem_data,
    input  mem_ready,
    input  ru_wr, ru_rd, ru_data,
    output iss_valid, iss_rs1, iss_rs2, iss_rd,
    input  iss_stall,
    input  busy
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and RAW/WAW scoreboard for the register unit's single write port.
// WB_RR_EN: round-robin on contention; otherwise MEM has fixed priority over ALU.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_wb_arbiter_if.slave   bus
);
  localparam int unsigned RW = $clog2(NREG);

  logic            grant_alu_c;
  logic            grant_mem_c;
  logic            grant_c;
  logic [RW-1:0]   wr_rd_c;
  logic [XLEN-1:0] wr_data_c;

  logic            ru_wr_q;
  logic [RW-1:0]   ru_rd_q;
  logic [XLEN-1:0] ru_data_q;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] set_c;
  logic [NREG-1:0] clr_c;
  logic            stall_c;

`ifdef WB_RR_EN
  logic mem_first_q;

  // Pointer only moves on contested grants
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_first_q <= 1'b0;
    end else if (bus.alu_valid && bus.mem_valid) begin
      mem_first_q <= !mem_first_q;
    end
  end

  always_comb begin
    grant_mem_c = bus.mem_valid && (!bus.alu_valid || mem_first_q);
  end
`else
  always_comb begin
    grant_mem_c = bus.mem_valid;
  end
`endif

  always_comb begin
    grant_alu_c = bus.alu_valid && !grant_mem_c;
    grant_c     = grant_alu_c || grant_mem_c;
    wr_rd_c     = grant_mem_c ? bus.mem_rd   : bus.alu_rd;
    wr_data_c   = grant_mem_c ? bus.mem_data : bus.alu_data;
  end

  // Hazard check uses registered busy only, so a same-cycle accept still stalls
  always_comb begin
    stall_c = bus.iss_valid &&
              (busy_q[bus.iss_rs1] || busy_q[bus.iss_rs2] || busy_q[bus.iss_rd]);
    set_c   = '0;
    clr_c   = '0;
    if (bus.iss_valid && !stall_c && (bus.iss_rd != '0)) begin
      set_c = NREG'(1) << bus.iss_rd;
    end
    if (grant_c) begin
      clr_c = NREG'(1) << wr_rd_c;
    end
    busy_d = ((busy_q & ~clr_c) | set_c) & ~NREG'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ru_wr_q   <= 1'b0;
      ru_rd_q   <= '0;
      ru_data_q <= '0;
      busy_q    <= '0;
    end else begin
      ru_wr_q <= grant_c && (wr_rd_c != '0);
      if (grant_c) begin
        ru_rd_q   <= wr_rd_c;
        ru_data_q <= wr_data_c;
      end
      busy_q <= busy_d;
    end
  end

  assign bus.alu_ready = grant_alu_c;
  assign bus.mem_ready = grant_mem_c;
  assign bus.ru_wr     = ru_wr_q;
  assign bus.ru_rd     = ru_rd_q;
  assign bus.ru_data   = ru_data_q;
  assign bus.iss_stall = stall_c;
  assign bus.busy      = busy_q;
endmodule
